branch_redirect: RTL and testbench

Fetch-side next-PC selection and misprediction recovery for the five-stage MIPS pipeline. Consumes the branch predictor's fetch-stage outputs (`bta`, `bpredsel`, `found`) to steer `pcnextf`, carries each prediction from F to D in a record register, checks it against the resolved outcome in D, and on a mismatch flushes the wrong-path instruction and redirects fetch. Sits between the predictor and the PC register / IF-ID pipeline register.

---
 rtl/branch_redirect.sv | 136 +++++++++++++
 tb/tb_branch_redirect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// branch_redirect: fetch-side next-PC selection with F->D prediction record,
// D-stage misprediction check, wrong-path flush and one-cycle SHADOW state.
// Optional statistics counters (br_count/mp_count) enabled by `BRP_STATS_EN.
module branch_redirect #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pcf,
    input  logic [31:0]      instrf,
    input  logic [31:0]      bta,
    input  logic             bpredsel,
    input  logic             found,
    input  logic             stalld,
    input  logic             branchd,
    input  logic             pcsrcd,
    input  logic [31:0]      pcbranchd,
    output logic [31:0]      pcnextf,
    output logic             flushd,
    output logic             mispredict,
    output logic             predtakend
`ifdef BRP_STATS_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
`endif
);

    typedef enum logic {RUN, SHADOW} state_t;

    state_t      state_q, state_d;
    logic        rv_q, rv_d;
    logic        rtaken_q, rtaken_d;
    logic [31:0] rtarget_q, rtarget_d;
    logic [31:0] rplus4_q, rplus4_d;

    logic        isbrf;
    logic        use_pred;
    logic        resolve;
    logic [31:0] pcplus4f;

    // Only the opcode field of the fetched instruction matters here.
    logic        unused_bits;
    assign unused_bits = ^{instrf[25:0], (CNT_W == 0)};

    assign pcplus4f = pcf + 32'd4;

    // F-side prediction use, D-side resolution and next-PC priority mux
    always_comb begin
        isbrf      = (instrf[31:26] == 6'b000100) || (instrf[31:26] == 6'b000101);
        // Predictor output is suppressed while reset is held so fetch falls through.
        use_pred   = isbrf & found & bpredsel & (state_q == RUN) & ~reset;
        resolve    = rv_q & branchd & ~stalld;
        mispredict = resolve & ((pcsrcd != rtaken_q) |
                                (pcsrcd & rtaken_q & (pcbranchd != rtarget_q)));
        flushd     = mispredict;
        predtakend = rtaken_q;
        if (mispredict) begin
            pcnextf = pcsrcd ? pcbranchd : rplus4_q;
        end else if (use_pred) begin
            pcnextf = bta;
        end else begin
            pcnextf = pcplus4f;
        end
    end

    // Next record contents and RUN/SHADOW transition
    always_comb begin
        rv_d      = rv_q;
        rtaken_d  = rtaken_q;
        rtarget_d = rtarget_q;
        rplus4_d  = rplus4_q;
        state_d   = state_q;
        if (flushd) begin
            rv_d      = 1'b0;
            rtaken_d  = 1'b0;
            rtarget_d = '0;
            rplus4_d  = '0;
        end else if (!stalld) begin
            rv_d      = isbrf;
            rtaken_d  = use_pred;
            rtarget_d = bta;
            rplus4_d  = pcplus4f;
        end
        case (state_q)
            RUN:     if (mispredict) state_d = SHADOW;
            SHADOW:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Record and state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv_q      <= 1'b0;
            rtaken_q  <= 1'b0;
            rtarget_q <= '0;
            rplus4_q  <= '0;
            state_q   <= RUN;
        end else begin
            rv_q      <= rv_d;
            rtaken_q  <= rtaken_d;
            rtarget_q <= rtarget_d;
            rplus4_q  <= rplus4_d;
            state_q   <= state_d;
        end
    end

`ifdef BRP_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Saturating resolution / misprediction counters
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (resolve && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
        if (mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_count = br_cnt_q;
    assign mp_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect: directed vector table followed by
// randomized cycles compared against a behavioural model. Counter checks are
// compiled in when BRP_STATS_EN is defined.
module tb_branch_redirect;

    localparam int unsigned CW = 4;
    localparam logic [31:0] BEQ = 32'h1000_0000;
    localparam logic [31:0] BNE = 32'h1400_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcf, instrf, bta, pcbranchd, pcnextf;
    logic        bpredsel, found, stalld, branchd, pcsrcd;
    logic        flushd, mispredict, predtakend;
`ifdef BRP_STATS_EN
    logic [CW-1:0] br_count, mp_count;
`endif

    always #5 clk = ~clk;

    branch_redirect #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pcf(pcf), .instrf(instrf), .bta(bta),
        .bpredsel(bpredsel), .found(found), .stalld(stalld), .branchd(branchd),
        .pcsrcd(pcsrcd), .pcbranchd(pcbranchd), .pcnextf(pcnextf),
        .flushd(flushd), .mispredict(mispredict), .predtakend(predtakend)
`ifdef BRP_STATS_EN
        , .br_count(br_count), .mp_count(mp_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc, ins, bt;
        logic        bp, fnd, stl, brd, src;
        logic [31:0] pcb;
        logic [31:0] e_next;
        logic        e_fl, e_mp, e_pt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the prediction travelling with the instruction now in D,
    // and whether the previous cycle redirected fetch.
    logic        m_valid, m_taken, m_prev_redirect;
    logic [31:0] m_target, m_ret;
    int          m_br, m_mp;

    function automatic vec_t mk(input logic r, input logic [31:0] pc, ins, bt,
                                input logic bp, fnd, stl, brd, src,
                                input logic [31:0] pcb, e_next,
                                input logic e_fl, e_mp, e_pt);
        vec_t v;
        v.rst = r; v.pc = pc; v.ins = ins; v.bt = bt; v.bp = bp; v.fnd = fnd;
        v.stl = stl; v.brd = brd; v.src = src; v.pcb = pcb;
        v.e_next = e_next; v.e_fl = e_fl; v.e_mp = e_mp; v.e_pt = e_pt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_taken = 0; m_target = 0; m_ret = 0;
        m_prev_redirect = 0; m_br = 0; m_mp = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input bit use_tbl, input vec_t v);
        logic        is_br, take_pred, resolved, wrong;
        logic [31:0] exp_next;
        reset = v.rst; pcf = v.pc; instrf = v.ins; bta = v.bt; bpredsel = v.bp;
        found = v.fnd; stalld = v.stl; branchd = v.brd; pcsrcd = v.src; pcbranchd = v.pcb;
        if (v.rst) model_clear();
        is_br     = (v.ins[31:26] == 6'd4) || (v.ins[31:26] == 6'd5);
        take_pred = is_br && v.fnd && v.bp && !m_prev_redirect && !v.rst;
        resolved  = m_valid && v.brd && !v.stl;
        wrong     = resolved && (v.src ? (!m_taken || v.pcb != m_target) : m_taken);
        if (wrong)          exp_next = v.src ? v.pcb : m_ret;
        else if (take_pred) exp_next = v.bt;
        else                exp_next = v.pc + 32'd4;
        @(negedge clk);
        if (use_tbl) begin
            chk("tbl_pcnextf", pcnextf, v.e_next);
            chk("tbl_flushd", {31'b0, flushd}, {31'b0, v.e_fl});
            chk("tbl_mispredict", {31'b0, mispredict}, {31'b0, v.e_mp});
            chk("tbl_predtakend", {31'b0, predtakend}, {31'b0, v.e_pt});
        end else begin
            chk("rnd_pcnextf", pcnextf, exp_next);
            chk("rnd_flushd", {31'b0, flushd}, {31'b0, wrong});
            chk("rnd_mispredict", {31'b0, mispredict}, {31'b0, wrong});
            chk("rnd_predtakend", {31'b0, predtakend}, {31'b0, m_taken});
        end
`ifdef BRP_STATS_EN
        chk("br_count", {28'b0, br_count}, m_br);
        chk("mp_count", {28'b0, mp_count}, m_mp);
`endif
        @(posedge clk);
        if (v.rst) begin
            model_clear();
        end else begin
            if (resolved && m_br < 15) m_br++;
            if (wrong && m_mp < 15) m_mp++;
            m_prev_redirect = wrong;
            if (wrong) begin
                m_valid = 0; m_taken = 0; m_target = 0; m_ret = 0;
            end else if (!v.stl) begin
                m_valid = is_br; m_taken = take_pred; m_target = v.bt; m_ret = v.pc + 32'd4;
            end
        end
        #1;
    endtask

    vec_t tbl[$];
    vec_t rv;
    logic [31:0] pool[4];

    initial begin
        model_clear();
        reset = 1; pcf = 0; instrf = 0; bta = 0; bpredsel = 0; found = 0;
        stalld = 0; branchd = 0; pcsrcd = 0; pcbranchd = 0;
        @(posedge clk); #1;

        //          rst pc             ins  bta        bp fnd stl brd src pcb        next          fl mp pt
        tbl.push_back(mk(1, 32'h100, BEQ, 32'h999, 1, 1, 0, 0, 0, 32'h0,   32'h104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, NOP, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h104, 0, 0, 0));
        tbl.push_back(mk(0, 32'h200, BEQ, 32'h240, 1, 1, 0, 0, 0, 32'h0,   32'h240, 0, 0, 0));
        tbl.push_back(mk(0, 32'h240, NOP, 32'h0,   0, 0, 0, 1, 1, 32'h240, 32'h244, 0, 0, 1));
        tbl.push_back(mk(0, 32'h300, BEQ, 32'h340, 1, 1, 0, 0, 0, 32'h0,   32'h340, 0, 0, 0));
        tbl.push_back(mk(0, 32'h340, BEQ, 32'h380, 1, 1, 0, 1, 0, 32'h340, 32'h304, 1, 1, 1));
        tbl.push_back(mk(0, 32'h304, BEQ, 32'h500, 1, 1, 0, 0, 0, 32'h0,   32'h308, 0, 0, 0));
        tbl.push_back(mk(0, 32'h308, BEQ, 32'h240, 1, 1, 0, 0, 0, 32'h0,   32'h240, 0, 0, 0));
        tbl.push_back(mk(0, 32'h240, NOP, 32'h0,   0, 0, 0, 1, 1, 32'h280, 32'h280, 1, 1, 1));
        tbl.push_back(mk(0, 32'h280, NOP, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h284, 0, 0, 0));
        tbl.push_back(mk(0, 32'h400, BNE, 32'h480, 1, 1, 0, 0, 0, 32'h0,   32'h480, 0, 0, 0));
        tbl.push_back(mk(0, 32'h480, NOP, 32'h0,   0, 0, 1, 1, 0, 32'h0,   32'h484, 0, 0, 1));
        tbl.push_back(mk(0, 32'h480, NOP, 32'h0,   0, 0, 1, 1, 0, 32'h0,   32'h484, 0, 0, 1));
        tbl.push_back(mk(0, 32'h480, NOP, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h404, 1, 1, 1));
        tbl.push_back(mk(0, 32'h404, NOP, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h408, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, NOP, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h104, 0, 0, 0));
        tbl.push_back(mk(0, 32'h600, NOP, 32'h0,   0, 0, 0, 1, 1, 32'h900, 32'h604, 0, 0, 0));
        tbl.push_back(mk(0, 32'h700, BEQ, 32'h7f0, 0, 1, 0, 0, 0, 32'h0,   32'h704, 0, 0, 0));
        tbl.push_back(mk(0, 32'h704, NOP, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h708, 0, 0, 0));
        tbl.push_back(mk(0, 32'hFFFF_FFFC, NOP, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));

        foreach (tbl[i]) step(1'b1, tbl[i]);

        // Randomized cycles against the model
        pool[0] = 32'h1000; pool[1] = 32'h1040; pool[2] = 32'h2000; pool[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2000; i++) begin
            rv.rst = ($urandom_range(0, 49) == 0);
            rv.pc  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : ($urandom & 32'hFFFF_FFFC);
            case ($urandom_range(0, 3))
                0:       rv.ins = BEQ | ($urandom & 32'h03FF_FFFF);
                1:       rv.ins = BNE | ($urandom & 32'h03FF_FFFF);
                default: rv.ins = $urandom;
            endcase
            rv.bt  = pool[$urandom_range(0, 3)];
            rv.bp  = $urandom_range(0, 3) != 0;
            rv.fnd = $urandom_range(0, 3) != 0;
            rv.stl = $urandom_range(0, 3) == 0;
            rv.brd = $urandom_range(0, 3) != 0;
            rv.src = $urandom_range(0, 1) == 1;
            rv.pcb = ($urandom_range(0, 1) == 0) ? m_target : pool[$urandom_range(0, 3)];
            rv.e_next = 0; rv.e_fl = 0; rv.e_mp = 0; rv.e_pt = 0;
            step(1'b0, rv);
        end

`ifdef BRP_STATS_EN
        // 20 mispredicted branches: counters saturate at 15
        step(1'b0, mk(1, 32'h100, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 20; k++) begin
            step(1'b0, mk(0, 32'h200, BEQ, 32'h240, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            step(1'b0, mk(0, 32'h240, NOP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            step(1'b0, mk(0, 32'h204, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        chk("br_count_sat", {28'b0, br_count}, 32'd15);
        chk("mp_count_sat", {28'b0, mp_count}, 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
